// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out
// reads (active video) and a buffered draw-engine write stream (blanking),
// with front/back double buffering that swaps at the start of vertical blank.
// Ports:
//   clock, reset                 pixel clock, async active-high reset
//   hCounter, vCounter, vidOn    scan position and active-video flag
//   refreshDraw                  1-cycle pulse at start of vertical blank
//   wr_valid/wr_ready/wr_addr/wr_data   draw-engine write stream
//   swap_req/swap_pending/swap_done/front_buf   buffer swap control/status
//   mem_addr/mem_we/mem_wdata/mem_rdata         framebuffer RAM port
//   pixel/pixel_valid            registered scan-out pixel
//   wr_err                       sticky out-of-range write drop flag
module vga_fb_arbiter #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned FB_PIXELS  = 307200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [9:0]       hCounter,
  input  logic [9:0]       vCounter,
  input  logic             vidOn,
  input  logic             refreshDraw,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [18:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             swap_req,
  output logic             swap_pending,
  output logic             swap_done,
  output logic             front_buf,
  output logic [19:0]      mem_addr,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  input  logic [PIX_W-1:0] mem_rdata,
  output logic [PIX_W-1:0] pixel,
  output logic             pixel_valid,
  output logic             wr_err
);

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned MEM_AW = ADDR_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              bsel;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } wr_entry_t;

  wr_entry_t fifo_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic              front_buf_q, front_buf_d;
  logic              swap_pending_q, swap_pending_d;
  logic              swap_done_q, swap_done_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              vid_d1_q, vid_d1_d;
  logic [PIX_W-1:0]  pixel_q, pixel_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              wr_err_q, wr_err_d;

  logic              push_c, pop_c;
  logic [ADDR_W-1:0] scan_addr_c;
  wr_entry_t         head_c;

  // Scan address v*640+h as shift-add for the standard line width.
  always_comb begin
    if (H_ACTIVE == 640) begin
      scan_addr_c = (ADDR_W'(vCounter) << 9) + (ADDR_W'(vCounter) << 7)
                  + ADDR_W'(hCounter);
    end else begin
      scan_addr_c = ADDR_W'(vCounter * H_ACTIVE) + ADDR_W'(hCounter);
    end
  end

  // Pops only happen outside active video so scan-out always owns the RAM.
  assign push_c = wr_valid && wr_ready_q;
  assign pop_c  = !vidOn && (count_q != '0);
  assign head_c = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    front_buf_d    = front_buf_q;
    swap_pending_d = swap_pending_q;
    swap_done_d    = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_we_d       = 1'b0;
    mem_wdata_d    = mem_wdata_q;
    wr_err_d       = wr_err_q;
    vid_d1_d       = vidOn;
    pixel_valid_d  = vid_d1_q;
    pixel_d        = vid_d1_q ? mem_rdata : '0;

    // FIFO occupancy
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Registered from next count, so a pop while full frees a slot next cycle.
    wr_ready_d = (count_d != CNT_W'(FIFO_DEPTH));

    // Swap: a request coincident with refreshDraw is consumed by that swap.
    if (refreshDraw && (swap_pending_q || swap_req)) begin
      front_buf_d    = ~front_buf_q;
      swap_pending_d = 1'b0;
      swap_done_d    = 1'b1;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end

    // RAM port ownership: SCAN, DRAIN or IDLE (address holds when idle).
    if (vidOn) begin
      mem_addr_d = {front_buf_q, scan_addr_c};
    end else if (pop_c) begin
      if (head_c.addr < ADDR_W'(FB_PIXELS)) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = {head_c.bsel, head_c.addr};
        mem_wdata_d = head_c.data;
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wr_ready_q     <= 1'b1;
      front_buf_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_done_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_we_q       <= 1'b0;
      mem_wdata_q    <= '0;
      vid_d1_q       <= 1'b0;
      pixel_q        <= '0;
      pixel_valid_q  <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wr_ready_q     <= wr_ready_d;
      front_buf_q    <= front_buf_d;
      swap_pending_q <= swap_pending_d;
      swap_done_q    <= swap_done_d;
      mem_addr_q     <= mem_addr_d;
      mem_we_q       <= mem_we_d;
      mem_wdata_q    <= mem_wdata_d;
      vid_d1_q       <= vid_d1_d;
      pixel_q        <= pixel_d;
      pixel_valid_q  <= pixel_valid_d;
      wr_err_q       <= wr_err_d;
    end
  end

  // Entry storage; the buffer tag is the back buffer at acceptance time.
  always_ff @(posedge clock) begin
    if (push_c) begin
      fifo_mem_q[wr_ptr_q] <= '{bsel: ~front_buf_q, addr: wr_addr, data: wr_data};
    end
  end

  assign wr_ready     = wr_ready_q;
  assign front_buf    = front_buf_q;
  assign swap_pending = swap_pending_q;
  assign swap_done    = swap_done_q;
  assign mem_addr     = mem_addr_q;
  assign mem_we       = mem_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign pixel        = pixel_q;
  assign pixel_valid  = pixel_valid_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter.
module tb_vga_fb_arbiter;

  localparam int unsigned PIX_W = 8;

  logic             clock;
  logic             reset;
  logic [9:0]       hCounter;
  logic [9:0]       vCounter;
  logic             vidOn;
  logic             refreshDraw;
  logic             wr_valid;
  logic             wr_ready;
  logic [18:0]      wr_addr;
  logic [PIX_W-1:0] wr_data;
  logic             swap_req;
  logic             swap_pending;
  logic             swap_done;
  logic             front_buf;
  logic [19:0]      mem_addr;
  logic             mem_we;
  logic [PIX_W-1:0] mem_wdata;
  logic [PIX_W-1:0] mem_rdata;
  logic [PIX_W-1:0] pixel;
  logic             pixel_valid;
  logic             wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  vga_fb_arbiter #(.PIX_W(PIX_W), .FIFO_DEPTH(8), .H_ACTIVE(640), .FB_PIXELS(307200)) dut (
    .clock(clock), .reset(reset), .hCounter(hCounter), .vCounter(vCounter),
    .vidOn(vidOn), .refreshDraw(refreshDraw), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
    .front_buf(front_buf), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel(pixel),
    .pixel_valid(pixel_valid), .wr_err(wr_err)
  );

  // RAM model: read data is a fixed function of the registered address.
  assign mem_rdata = mem_addr[7:0] ^ 8'h3C;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hCounter = '0; vCounter = '0; vidOn = 1'b0; refreshDraw = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
    step(); step();
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %0d expected 1", wr_ready); end
    n_checks++; if (front_buf !== 1'b0) begin n_fail++; $display("FAIL reset_front_buf: got %0d expected 0", front_buf); end
    n_checks++; if (swap_pending !== 1'b0 || swap_done !== 1'b0) begin n_fail++; $display("FAIL reset_swap: got %0d/%0d expected 0/0", swap_pending, swap_done); end
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 20'd0 || mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem: got we=%0d addr=%0d wdata=%0h expected 0/0/0", mem_we, mem_addr, mem_wdata); end
    n_checks++; if (pixel !== 8'h00 || pixel_valid !== 1'b0 || wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_err: got %0h/%0d/%0d expected 0/0/0", pixel, pixel_valid, wr_err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_scan();
    hCounter = 10'd5; vCounter = 10'd2; vidOn = 1'b1;
    step();
    n_checks++; if (mem_addr !== 20'd1285 || mem_we !== 1'b0) begin n_fail++; $display("FAIL scan_addr: got addr=%0d we=%0d expected 1285/0", mem_addr, mem_we); end
    n_checks++; if (pixel_valid !== 1'b0) begin n_fail++; $display("FAIL scan_valid_early: got %0d expected 0", pixel_valid); end
    step();
    n_checks++; if (pixel_valid !== 1'b1 || pixel !== 8'h39) begin n_fail++; $display("FAIL scan_pixel: got valid=%0d pixel=%0h expected 1/39", pixel_valid, pixel); end
    vidOn = 1'b0;
    step(); step();
    n_checks++; if (pixel_valid !== 1'b0 || pixel !== 8'h00) begin n_fail++; $display("FAIL scan_blank_pixel: got valid=%0d pixel=%0h expected 0/0", pixel_valid, pixel); end
  endtask

  task automatic test_holdoff();
    hCounter = 10'd10; vCounter = 10'd3; vidOn = 1'b1;
    wr_valid = 1'b1; wr_addr = 19'd100; wr_data = 8'hAA;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL holdoff_we_%0d: got %0d expected 0", i, mem_we); end
    end
    vidOn = 1'b0;
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 20'd524388 || mem_wdata !== 8'hAA) begin n_fail++; $display("FAIL holdoff_write: got we=%0d addr=%0d wdata=%0h expected 1/524388/aa", mem_we, mem_addr, mem_wdata); end
    step();
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 20'd524388) begin n_fail++; $display("FAIL holdoff_idle: got we=%0d addr=%0d expected 0/524388", mem_we, mem_addr); end
  endtask

  task automatic test_backpressure();
    hCounter = 10'd20; vCounter = 10'd4; vidOn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_addr = 19'(200 + i); wr_data = 8'(8'h10 + i);
      step();
    end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got wr_ready=%0d expected 0", wr_ready); end
    wr_addr = 19'd208; wr_data = 8'h18;
    step();
    n_checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL bp_held: got wr_ready=%0d we=%0d expected 0/0", wr_ready, mem_we); end
    vidOn = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 1) wr_valid = 1'b0;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 20'(524288 + 200 + k) || mem_wdata !== 8'(8'h10 + k)) begin
        n_fail++; $display("FAIL bp_drain_%0d: got we=%0d addr=%0d wdata=%0h expected 1/%0d/%0h", k, mem_we, mem_addr, mem_wdata, 524488 + k, 8'h10 + k);
      end
      if (k == 0) begin
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %0d expected 1", wr_ready); end
      end
    end
    step();
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got we=%0d expected 0", mem_we); end
  endtask

  task automatic test_swap();
    hCounter = 10'd0; vCounter = 10'd100; vidOn = 1'b1; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_checks++; if (swap_pending !== 1'b1 || front_buf !== 1'b0 || swap_done !== 1'b0) begin n_fail++; $display("FAIL swap_pending: got %0d/%0d/%0d expected 1/0/0", swap_pending, front_buf, swap_done); end
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_checks++; if (swap_pending !== 1'b1 || front_buf !== 1'b0) begin n_fail++; $display("FAIL swap_repeat_req: got %0d/%0d expected 1/0", swap_pending, front_buf); end
    vidOn = 1'b0; vCounter = 10'd480; hCounter = 10'd635; refreshDraw = 1'b1;
    step();
    refreshDraw = 1'b0; hCounter = 10'd636;
    n_checks++; if (front_buf !== 1'b1 || swap_done !== 1'b1 || swap_pending !== 1'b0) begin n_fail++; $display("FAIL swap_apply: got front=%0d done=%0d pend=%0d expected 1/1/0", front_buf, swap_done, swap_pending); end
    step();
    n_checks++; if (swap_done !== 1'b0 || front_buf !== 1'b1) begin n_fail++; $display("FAIL swap_done_pulse: got done=%0d front=%0d expected 0/1", swap_done, front_buf); end
    refreshDraw = 1'b1;
    step();
    refreshDraw = 1'b0;
    n_checks++; if (front_buf !== 1'b1 || swap_done !== 1'b0) begin n_fail++; $display("FAIL swap_no_extra: got front=%0d done=%0d expected 1/0", front_buf, swap_done); end
    hCounter = 10'd5; vCounter = 10'd2; vidOn = 1'b1;
    step();
    n_checks++; if (mem_addr !== 20'd525573) begin n_fail++; $display("FAIL swap_scan_front1: got addr=%0d expected 525573", mem_addr); end
  endtask

  task automatic test_swap_fifo();
    reset = 1'b1; vidOn = 1'b0;
    step();
    reset = 1'b0;
    wr_valid = 1'b1; wr_addr = 19'd300; wr_data = 8'h55; refreshDraw = 1'b1; swap_req = 1'b1;
    step();
    wr_valid = 1'b0; refreshDraw = 1'b0; swap_req = 1'b0;
    n_checks++; if (front_buf !== 1'b1 || swap_done !== 1'b1 || swap_pending !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sf_coincident_swap: got front=%0d done=%0d pend=%0d we=%0d expected 1/1/0/0", front_buf, swap_done, swap_pending, mem_we); end
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 20'd524588 || mem_wdata !== 8'h55) begin n_fail++; $display("FAIL sf_old_back: got we=%0d addr=%0d wdata=%0h expected 1/524588/55", mem_we, mem_addr, mem_wdata); end
    hCounter = 10'd7; vCounter = 10'd7; vidOn = 1'b1;
    wr_valid = 1'b1; wr_addr = 19'd301; wr_data = 8'h66;
    step();
    wr_valid = 1'b0; vidOn = 1'b0;
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 20'd301 || mem_wdata !== 8'h66) begin n_fail++; $display("FAIL sf_new_back: got we=%0d addr=%0d wdata=%0h expected 1/301/66", mem_we, mem_addr, mem_wdata); end
  endtask

  task automatic test_error();
    hCounter = 10'd1; vCounter = 10'd1; vidOn = 1'b1;
    wr_valid = 1'b1; wr_addr = 19'd307200; wr_data = 8'h77;
    step();
    wr_addr = 19'd307199; wr_data = 8'h78;
    step();
    wr_valid = 1'b0; vidOn = 1'b0;
    step();
    n_checks++; if (mem_we !== 1'b0 || wr_err !== 1'b1) begin n_fail++; $display("FAIL err_drop: got we=%0d err=%0d expected 0/1", mem_we, wr_err); end
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 20'd307199 || mem_wdata !== 8'h78 || wr_err !== 1'b1) begin n_fail++; $display("FAIL err_last_valid: got we=%0d addr=%0d wdata=%0h err=%0d expected 1/307199/78/1", mem_we, mem_addr, mem_wdata, wr_err); end
    step();
    n_checks++; if (wr_err !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL err_sticky: got err=%0d we=%0d expected 1/0", wr_err, mem_we); end
  endtask

  task automatic test_reset_mid_drain();
    hCounter = 10'd2; vCounter = 10'd2; vidOn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = 19'(400 + i); wr_data = 8'(8'h30 + i);
      step();
    end
    wr_valid = 1'b0; vidOn = 1'b0;
    step();
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 20'd400) begin n_fail++; $display("FAIL rst_drain_start: got we=%0d addr=%0d expected 1/400", mem_we, mem_addr); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0 || wr_err !== 1'b0 || front_buf !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async: got we=%0d err=%0d front=%0d ready=%0d expected 0/0/0/1", mem_we, wr_err, front_buf, wr_ready); end
    step();
    reset = 1'b0;
    step();
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 20'd0) begin n_fail++; $display("FAIL rst_no_partial: got we=%0d addr=%0d expected 0/0", mem_we, mem_addr); end
    step();
    n_checks++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fifo_empty: got we=%0d ready=%0d expected 0/1", mem_we, wr_ready); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_holdoff();
    test_backpressure();
    test_swap();
    test_swap_fifo();
    test_error();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
